// File: rtl/invaders_loader_pkg.sv
// Shared types and constants for the Invaders ROM download sequencer.
// Holds the FSM encoding, memory-map bases and default parameters.
package invaders_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } loader_state_t;

  localparam logic [15:0] ROM_BASE  = 16'h0000;
  localparam logic [15:0] ROM2_BASE = 16'h2000;
  localparam logic [15:0] VROM_BASE = 16'h4000;

  // Colour PROM is 2 KiB, so the image ends at its last byte
  localparam logic [15:0] PAD_END_DEFAULT = VROM_BASE + 16'h07FF;
  localparam logic [7:0]  ROM_INDEX_DEFAULT = 8'h00;

  function automatic logic [16:0] hw_max(
    input logic [16:0] hw,
    input logic [15:0] addr
  );
    logic [16:0] nxt;
    nxt = {1'b0, addr} + 17'd1;
    return (nxt > hw) ? nxt : hw;
  endfunction

endpackage

// File: rtl/invaders_rom_loader.sv
// ioctl-to-memory download sequencer: load, zero-pad, then release the CPU.
// Optional checksum accumulator: INVADERS_LOADER_CHECKSUM_EN.
module invaders_rom_loader
  import invaders_loader_pkg::*;
#(
  parameter logic [15:0] PAD_END   = PAD_END_DEFAULT,
  parameter logic [7:0]  ROM_INDEX = ROM_INDEX_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        cpu_reset,
  output logic        rom_ready,
  output logic [15:0] byte_count,
  output logic [7:0]  checksum
);

  loader_state_t state;
  loader_state_t state_nx;

  logic        dl_q;
  logic        rise;
  logic        fall;
  logic        idx_ok;
  logic        start;
  logic        accept;
  logic [16:0] hw;
  logic [16:0] hw_nx;
  logic [15:0] pc;

  logic        wr_d;
  logic [15:0] addr_d;
  logic [7:0]  data_d;
  logic        ready_d;
  logic        creset_d;
  logic        wait_d;

  assign idx_ok = (ioctl_index == ROM_INDEX);
  assign rise   = ioctl_download & ~dl_q;
  assign fall   = ~ioctl_download & dl_q;
  assign start  = rise & idx_ok;

  assign accept = (state == S_LOAD) & ioctl_wr & idx_ok
                & (ioctl_addr <= {9'd0, PAD_END});

  assign hw_nx = accept ? hw_max(hw, ioctl_addr[15:0]) : hw;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // hw_nx folds in a strobe coincident with the falling edge
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (fall) begin
          if (hw_nx > {1'b0, PAD_END}) state_nx = S_DONE;
          else                         state_nx = S_PAD;
        end
      end
      S_PAD: begin
        if (start)               state_nx = S_LOAD;
        else if (pc == PAD_END)  state_nx = S_DONE;
      end
      S_DONE: begin
        if (start) state_nx = S_LOAD;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d     = 1'b0;
    addr_d   = dn_addr;
    data_d   = dn_data;
    ready_d  = (state == S_DONE);
    creset_d = (state != S_DONE);
    wait_d   = (state == S_PAD);
    if (accept) begin
      wr_d   = 1'b1;
      addr_d = ioctl_addr[15:0];
      data_d = ioctl_dout;
    end else if ((state == S_PAD) && !start) begin
      wr_d   = 1'b1;
      addr_d = pc;
      data_d = 8'h00;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dl_q       <= 1'b0;
      dn_wr      <= 1'b0;
      dn_addr    <= 16'h0000;
      dn_data    <= 8'h00;
      cpu_reset  <= 1'b1;
      rom_ready  <= 1'b0;
      ioctl_wait <= 1'b0;
    end else begin
      dl_q       <= ioctl_download;
      dn_wr      <= wr_d;
      dn_addr    <= addr_d;
      dn_data    <= data_d;
      cpu_reset  <= creset_d;
      rom_ready  <= ready_d;
      ioctl_wait <= wait_d;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hw         <= 17'd0;
      byte_count <= 16'h0000;
    end else if (start) begin
      hw         <= 17'd0;
      byte_count <= 16'h0000;
    end else if (accept) begin
      hw <= hw_nx;
      if (byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
    end
  end

  // Pad resumes at the high-water mark; holes below it stay untouched
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc <= 16'h0000;
    end else if ((state == S_LOAD) && fall) begin
      pc <= hw_nx[15:0];
    end else if (state == S_PAD) begin
      pc <= pc + 16'd1;
    end
  end

`ifdef INVADERS_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sum <= 8'h00;
    end else if (start) begin
      sum <= 8'h00;
    end else if (accept) begin
      sum <= sum + ioctl_dout;
    end
  end

  assign checksum = sum;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: doc/invaders_rom_loader.md
# invaders_rom_loader

Download sequencer driving the ROM/colour-PROM write port of the Invaders memory block. Converts the HPS ioctl byte stream (index 0) into single-cycle `dn_addr`/`dn_data`/`dn_wr` writes, then zero-pads every address the image did not cover up to `PAD_END`. It holds the CPU in reset until the image is complete. Sits between the top-level ioctl bus and the memory block.

## Interface
Parameters:
- `PAD_END`, 16'h47FF: last download address padded. Covers program ROM 0000-1FFF, high ROM 2000-3FFF and colour PROM 4000-47FF.
- `ROM_INDEX`, 8'h00: ioctl index accepted as the ROM image.

Ports:
- `Clock`  in  1  system clock; everything is single-clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `ioctl_download`  in  1  download window active.
- `ioctl_index`  in  8  download target; only `ROM_INDEX` is acted on.
- `ioctl_wr`  in  1  byte strobe, one cycle per byte.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_wait`  out  1  backpressure to the HPS; high during PAD.
- `dn_addr`  out  16  write address to memory.
- `dn_data`  out  8  write data.
- `dn_wr`  out  1  write strobe, one cycle per byte.
- `cpu_reset`  out  1  CPU reset request.
- `rom_ready`  out  1  image complete.
- `byte_count`  out  16  number of accepted bytes in the current download.
- `checksum`  out  8  additive checksum of accepted bytes (see Configuration).

## Operation
States: IDLE, LOAD, PAD, DONE. Encoding lives in the package.

- **IDLE**
  - Entered on `Reset`.
  - Goes to LOAD on a rising edge of `ioctl_download` while `ioctl_index==ROM_INDEX`.
  - A rising edge of `ioctl_download` is detected as current high, registered previous value low.
- **LOAD entry**
  - Clears `byte_count`, the `checksum` accumulator and the high-water mark `hw` (17 bits).
- **LOAD**
  - Each `ioctl_wr` with `ioctl_addr<=PAD_END` is an accepted byte:
    - registered to `dn_addr=ioctl_addr[15:0]`, `dn_data=ioctl_dout`, `dn_wr=1` for one cycle;
    - `byte_count` increments (saturates at FFFF);
    - `hw=max(hw, addr+1)`.
  - `ioctl_wr` with `ioctl_addr>PAD_END` is dropped: no `dn_wr`, no count.
  - Back-to-back strobes are accepted every cycle.
  - On a falling edge of `ioctl_download`:
    - goes to PAD if `hw<=PAD_END`;
    - goes directly to DONE if `hw>PAD_END`, i.e. the image is full.
- **PAD**
  - A pad counter `pc` starts at `hw`.
  - Each cycle it emits `dn_addr=pc`, `dn_data=00`, `dn_wr=1`, then increments `pc`.
  - After the write at `pc==PAD_END`, goes to DONE.
  - Holes below `hw` are not padded.
  - `ioctl_wr` is ignored in PAD.
- **DONE**
  - `rom_ready=1`, `cpu_reset=0`.
  - A new rising edge of `ioctl_download` with matching index goes back to LOAD (`rom_ready=0`, `cpu_reset=1`).
- **Non-matching index**
  - Downloads with `ioctl_index!=ROM_INDEX` are ignored entirely in every state. No state change, no writes.
- **Restart during PAD**
  - A rising edge of `ioctl_download` with matching index aborts PAD and goes to LOAD. A fresh pad runs after that download ends.
- **Output rules**
  - `cpu_reset=1` in IDLE, LOAD and PAD.
  - `ioctl_wait=1` only in PAD.

## Timing
- Reset values:
  - state IDLE;
  - `dn_wr=0`, `dn_addr=0000`, `dn_data=00`;
  - `cpu_reset=1`, `rom_ready=0`, `ioctl_wait=0`;
  - `byte_count=0`, `checksum=00`.
- Latency: `ioctl_wr` at cycle N gives `dn_wr` at N+1. All outputs are registered.
- End of download: falling edge of `ioctl_download` seen at cycle M.
  - The first pad write appears at M+2.
  - `rom_ready` rises the cycle after the last pad write.
  - If there is no pad, `rom_ready` rises at M+2.
- A strobe in the same cycle as the falling edge of `ioctl_download` is still accepted and precedes the pad writes.
- `Reset` asserted mid-LOAD or mid-PAD: the state goes to IDLE immediately (asynchronously), `dn_wr` drops, and no partial write is issued after reset.

## Configuration
- Macro `INVADERS_LOADER_CHECKSUM_EN`.
- **Defined:** `checksum` is the mod-256 sum of the `dn_data` of all accepted bytes.
  - Pad bytes are excluded.
  - The value is updated on the same cycle `dn_wr` is issued.
  - The value is held through DONE.
- **Undefined:** the accumulator is not built and `checksum` is tied to 8'h00.
- All other behaviour is identical with or without the macro.

## Structure
- Package `invaders_loader_pkg`:
  - state enum `loader_state_t`;
  - region base constants `ROM_BASE=16'h0000`, `ROM2_BASE=16'h2000`, `VROM_BASE=16'h4000`;
  - default `PAD_END`.
- Single module; no sub-module needed. Edge detection and the pad counter are local registers.

## Test plan
- Full 0x4800-byte image, `ioctl_addr` 0..47FF, data=`addr[7:0]`:
  - 0x4800 `dn_wr` pulses, each one cycle after its strobe;
  - no pad writes;
  - `rom_ready=1` two cycles after the falling edge;
  - `checksum=00` (0x4800 bytes, each 256-byte block summing to 0x80, 72 blocks, sum mod 256 = 00);
  - `byte_count=4800`.
- Short image, 0x2000 bytes of 0xFF:
  - pad writes 00 to 2000..47FF (0x2800 writes) with `ioctl_wait=1` throughout;
  - `cpu_reset` drops after the write to 47FF.
- Out-of-range byte at `ioctl_addr=0x8000` mid-stream: no `dn_wr`, `byte_count` unchanged.
- Index 1 download of 16 bytes in DONE: state stays DONE, no `dn_wr`, `rom_ready` stays 1.
- `Reset` pulse during PAD at `pc=3000`:
  - `dn_wr=0` and `cpu_reset=1` immediately;
  - state IDLE;
  - the next matching download restarts cleanly with `byte_count=0`.
- Restart: `ioctl_download` rises again during PAD:
  - pad aborts and LOAD is entered;
  - the new image's pad begins at that download's `hw`.
